// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer for the phase-1 CPU datapath.
// One micro-step per clock: T0-T2 fetch, T3-T6 execute register-register ALU and MUL/DIV ops.
module control_unit #(
    parameter logic [4:0] HALT_OP = 5'b11011
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] IR,
    input  logic        MemReady,
    input  logic        Stop,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        LOin,
    output logic        HIin,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [4:0]  ALU_op,
    output logic        Run,
    output logic [15:0] InstrCount
);

    typedef enum logic [3:0] {
        S_RST,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_t;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b00110;
    localparam logic [4:0] OP_MUL = 5'b01000;
    localparam logic [4:0] OP_DIV = 5'b01001;

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       is_muldiv;
    logic       is_alu;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign unused_ir = ^IR[14:0];

    assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign is_alu    = is_muldiv || (opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR});

    function automatic logic [15:0] dec16(input logic [3:0] idx);
        dec16 = 16'h0001 << idx;
    endfunction

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_RST;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        PCout    = 1'b0;
        PCin     = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        LOin     = 1'b0;
        HIin     = 1'b0;
        Rin      = '0;
        Rout     = '0;
        ALU_op   = '0;
        Run      = 1'b1;

        unique case (state_q)
            S_RST: state_d = S_T0;

            // A stop request is only honoured at the instruction boundary and suppresses the fetch.
            S_T0: begin
                if (Stop) begin
                    state_d = S_HALT;
                end else begin
                    PCout   = 1'b1;
                    MARin   = 1'b1;
                    IncPC   = 1'b1;
                    Zin     = 1'b1;
                    state_d = S_T1;
                end
            end

            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = MemReady;
                if (MemReady) begin
                    state_d = S_T2;
                end
            end

            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                count_d = count_q + 16'd1;
                state_d = S_T3;
            end

            // HALT_OP is tested first so it wins even if it aliases an ALU opcode.
            S_T3: begin
                if (opcode == HALT_OP) begin
                    state_d = S_HALT;
                end else if (is_alu) begin
                    Rout    = dec16(rb);
                    Yin     = 1'b1;
                    state_d = S_T4;
                end else begin
                    state_d = S_T0;
                end
            end

            S_T4: begin
                Rout    = dec16(rc);
                ALU_op  = opcode;
                Zin     = 1'b1;
                state_d = S_T5;
            end

            S_T5: begin
                Zlowout = 1'b1;
                if (is_muldiv) begin
                    LOin    = 1'b1;
                    state_d = S_T6;
                end else begin
                    Rin     = dec16(ra);
                    state_d = S_T0;
                end
            end

            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                state_d  = S_T0;
            end

            S_HALT: Run = 1'b0;

            default: state_d = S_RST;
        endcase
    end

    assign InstrCount = count_q;

    assert property (@(posedge Clock) disable iff (Reset) $onehot0(Rin));
    assert property (@(posedge Clock) disable iff (Reset) $onehot0(Rout));
    assert property (@(posedge Clock) disable iff (Reset) !(LOin && (Rin != '0)));

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: cycle-by-cycle strobe checks for fetch, ALU, MUL/DIV,
// memory wait, NOP, HALT, Stop and mid-instruction reset.
module tb_control_unit;

    logic        Clock;
    logic        Reset;
    logic [31:0] IR;
    logic        MemReady;
    logic        Stop;
    logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
    logic        Yin, Zin, Zlowout, Zhighout, LOin, HIin;
    logic [15:0] Rin, Rout;
    logic [4:0]  ALU_op;
    logic        Run;
    logic [15:0] InstrCount;

    control_unit #(.HALT_OP(5'b11011)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .IR         (IR),
        .MemReady   (MemReady),
        .Stop       (Stop),
        .PCout      (PCout),
        .PCin       (PCin),
        .IncPC      (IncPC),
        .MARin      (MARin),
        .Read       (Read),
        .MDRin      (MDRin),
        .MDRout     (MDRout),
        .IRin       (IRin),
        .Yin        (Yin),
        .Zin        (Zin),
        .Zlowout    (Zlowout),
        .Zhighout   (Zhighout),
        .LOin       (LOin),
        .HIin       (HIin),
        .Rin        (Rin),
        .Rout       (Rout),
        .ALU_op     (ALU_op),
        .Run        (Run),
        .InstrCount (InstrCount)
    );

    localparam logic [13:0] PCO = 14'h2000;
    localparam logic [13:0] PCI = 14'h1000;
    localparam logic [13:0] INC = 14'h0800;
    localparam logic [13:0] MAR = 14'h0400;
    localparam logic [13:0] RD  = 14'h0200;
    localparam logic [13:0] MDI = 14'h0100;
    localparam logic [13:0] MDO = 14'h0080;
    localparam logic [13:0] IRI = 14'h0040;
    localparam logic [13:0] YI  = 14'h0020;
    localparam logic [13:0] ZI  = 14'h0010;
    localparam logic [13:0] ZLO = 14'h0008;
    localparam logic [13:0] ZHI = 14'h0004;
    localparam logic [13:0] LOI = 14'h0002;
    localparam logic [13:0] HII = 14'h0001;

    logic [13:0] strb;
    assign strb = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
                   Yin, Zin, Zlowout, Zhighout, LOin, HIin};

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = '0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge Clock);
    endtask

    task automatic chk(input string tag, input logic [13:0] s, input logic [15:0] rin,
                       input logic [15:0] rout, input logic [4:0] op, input logic run);
        #1;
        checks++;
        assert (strb === s) else begin
            errors++;
            $error("FAIL %s strobes got %h want %h", tag, strb, s);
        end
        checks++;
        assert (Rin === rin) else begin
            errors++;
            $error("FAIL %s Rin got %h want %h", tag, Rin, rin);
        end
        checks++;
        assert (Rout === rout) else begin
            errors++;
            $error("FAIL %s Rout got %h want %h", tag, Rout, rout);
        end
        checks++;
        assert (ALU_op === op) else begin
            errors++;
            $error("FAIL %s ALU_op got %b want %b", tag, ALU_op, op);
        end
        checks++;
        assert (Run === run) else begin
            errors++;
            $error("FAIL %s Run got %b want %b", tag, Run, run);
        end
    endtask

    task automatic chk_cnt(input string tag);
        checks++;
        assert (InstrCount === exp_cnt) else begin
            errors++;
            $error("FAIL %s InstrCount got %0d want %0d", tag, InstrCount, exp_cnt);
        end
    endtask

    // T0 through T2; IR is presented while T2 is active so it is stable for decode in T3.
    task automatic fetch(input string tag, input logic [31:0] w, input int unsigned waits);
        tick();
        MemReady = 1'b1;
        chk({tag, "/T0"}, PCO | MAR | INC | ZI, '0, '0, '0, 1'b1);
        for (int unsigned i = 0; i < waits; i++) begin
            tick();
            MemReady = 1'b0;
            chk({tag, "/T1wait"}, ZLO | PCI | RD, '0, '0, '0, 1'b1);
        end
        tick();
        MemReady = 1'b1;
        chk({tag, "/T1"}, ZLO | PCI | RD | MDI, '0, '0, '0, 1'b1);
        tick();
        IR = w;
        chk({tag, "/T2"}, MDO | IRI, '0, '0, '0, 1'b1);
        exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic do_instr(input string tag, input logic [31:0] w, input int unsigned waits,
                            input bit stop_t4, input bit rst_t4);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        bit         md;
        op = w[31:27];
        ra = w[26:23];
        rb = w[22:19];
        rc = w[18:15];
        md = (op == 5'b01000) || (op == 5'b01001);
        fetch(tag, w, waits);
        tick();
        chk({tag, "/T3"}, YI, '0, 16'h0001 << rb, '0, 1'b1);
        chk_cnt({tag, "/T3cnt"});
        tick();
        Stop = stop_t4;
        chk({tag, "/T4"}, ZI, '0, 16'h0001 << rc, op, 1'b1);
        if (rst_t4) begin
            Reset = 1'b1;
            chk({tag, "/rstT4"}, '0, '0, '0, '0, 1'b1);
            exp_cnt = '0;
            chk_cnt({tag, "/rstcnt"});
            return;
        end
        tick();
        if (md) begin
            chk({tag, "/T5"}, ZLO | LOI, '0, '0, '0, 1'b1);
            tick();
            chk({tag, "/T6"}, ZHI | HII, '0, '0, '0, 1'b1);
        end else begin
            chk({tag, "/T5"}, ZLO, 16'h0001 << ra, '0, '0, 1'b1);
        end
    endtask

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
        enc = {op, ra, rb, rc, 15'd0};
    endfunction

    initial begin
        Reset    = 1'b0;
        Stop     = 1'b0;
        MemReady = 1'b1;
        IR       = '0;

        #2 Reset = 1'b1;
        chk("reset", '0, '0, '0, '0, 1'b1);
        chk_cnt("reset");
        tick();
        Reset = 1'b0;
        chk("rst_state", '0, '0, '0, '0, 1'b1);

        // DIV R5,R2,R4: T0..T6 back-to-back
        do_instr("div", 32'h4A920000, 0, 1'b0, 1'b0);
        // ADD R3,R1,R7
        do_instr("add", enc(5'b00011, 4'd3, 4'd1, 4'd7), 0, 1'b0, 1'b0);
        // OR with three memory wait cycles
        do_instr("orw", enc(5'b00110, 4'd1, 4'd2, 4'd3), 3, 1'b0, 1'b0);
        do_instr("mul", enc(5'b01000, 4'd6, 4'd9, 4'd10), 1, 1'b0, 1'b0);
        do_instr("and", enc(5'b00101, 4'd15, 4'd0, 4'd14), 0, 1'b0, 1'b0);

        // Illegal opcode: no execute strobes, back to T0, count still advances
        fetch("nop", enc(5'b11111, 4'd2, 4'd3, 4'd4), 0);
        tick();
        chk("nop/T3", '0, '0, '0, '0, 1'b1);
        chk_cnt("nop/cnt");

        fetch("halt", enc(5'b11011, 4'd1, 4'd1, 4'd1), 0);
        tick();
        chk("halt/T3", '0, '0, '0, '0, 1'b1);
        chk_cnt("halt/cnt");
        for (int i = 0; i < 20; i++) begin
            tick();
            MemReady = i[0];
            Stop     = i[1];
            chk("halt/idle", '0, '0, '0, '0, 1'b0);
        end
        chk_cnt("halt/cntkeep");

        Reset = 1'b1;
        Stop  = 1'b0;
        chk("reset2", '0, '0, '0, '0, 1'b1);
        exp_cnt = '0;
        chk_cnt("reset2");
        tick();
        Reset = 1'b0;
        chk("rst_state2", '0, '0, '0, '0, 1'b1);

        // Stop raised in T4: ADD still writes back, then halts at the next boundary
        do_instr("stop", enc(5'b00011, 4'd3, 4'd1, 4'd7), 0, 1'b1, 1'b0);
        tick();
        MemReady = 1'b1;
        chk("stop/T0", '0, '0, '0, '0, 1'b1);
        tick();
        chk("stop/halt", '0, '0, '0, '0, 1'b0);
        chk_cnt("stop/cnt");
        Stop = 1'b0;
        tick();
        chk("stop/stay", '0, '0, '0, '0, 1'b0);

        Reset = 1'b1;
        chk("reset3", '0, '0, '0, '0, 1'b1);
        exp_cnt = '0;
        tick();
        Reset = 1'b0;
        chk("rst_state3", '0, '0, '0, '0, 1'b1);

        // Reset asserted mid-T4 abandons the ADD before any register write
        do_instr("rst", enc(5'b00011, 4'd3, 4'd1, 4'd7), 0, 1'b0, 1'b1);
        tick();
        chk("rst/hold", '0, '0, '0, '0, 1'b1);
        Reset = 1'b0;
        chk("rst/rel", '0, '0, '0, '0, 1'b1);
        do_instr("post", enc(5'b00100, 4'd2, 4'd4, 4'd6), 0, 1'b0, 1'b0);
        chk_cnt("post/cnt");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
